// File: rtl/counter_pkg.sv
// Shared constants for counter_updown_hex: segment encoding table and a
// constant log2 helper used to size the prescaler.
package counter_pkg;

  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low segments, bit order g..a, indexed by nibble value.
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Smallest r with 2**r >= v, never below 1, so a register is always at least one bit wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One hex digit to active-low 7-segment pattern (bit 0 = segment a).
module seg7_decoder
  import counter_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_TABLE[0];
      4'h1: seg = SEG_TABLE[1];
      4'h2: seg = SEG_TABLE[2];
      4'h3: seg = SEG_TABLE[3];
      4'h4: seg = SEG_TABLE[4];
      4'h5: seg = SEG_TABLE[5];
      4'h6: seg = SEG_TABLE[6];
      4'h7: seg = SEG_TABLE[7];
      4'h8: seg = SEG_TABLE[8];
      4'h9: seg = SEG_TABLE[9];
      4'hA: seg = SEG_TABLE[10];
      4'hB: seg = SEG_TABLE[11];
      4'hC: seg = SEG_TABLE[12];
      4'hD: seg = SEG_TABLE[13];
      4'hE: seg = SEG_TABLE[14];
      default: seg = SEG_TABLE[15];
    endcase
  end

endmodule

// File: rtl/counter_updown_hex.sv
// Up/down modulus counter with load, wrap/saturate, prescaled enable and cascade Tc.
// HEX segment drive is built only when COUNTER_UPDOWN_HEX_DISPLAY_EN is defined; otherwise HEX is blank.
module counter_updown_hex
  import counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MODULUS  = 0,
  parameter int PRESCALE = 1
) (
  input  logic                       Clk,
  input  logic                       Clr,
  input  logic                       En,
  input  logic                       Up,
  input  logic                       Sat,
  input  logic                       Load,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       Tc,
  output logic                       Wrap,
  output logic [SEG_W*(WIDTH/4)-1:0] HEX
);

  localparam int NDIG = WIDTH / 4;
  localparam int PW   = clog2(PRESCALE);

  // Held in WIDTH+1 bits so MODULUS=0 (full 2**WIDTH range) does not overflow.
  localparam logic [WIDTH:0] MOD_EXT = (MODULUS == 0) ? ((WIDTH+1)'(1) << WIDTH)
                                                      : (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT  = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX      = MAX_EXT[WIDTH-1:0];
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic [PW-1:0]    pre_d, pre_q;
  logic             wrap_d, wrap_q;
  logic             tick;
  logic             at_end;

  assign tick   = En & (pre_q == PRE_LAST);
  assign at_end = Up ? (q_q == MAX) : (q_q == '0);

  always_comb begin
    q_d    = q_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (Load) begin
      q_d   = ({1'b0, D} >= MOD_EXT) ? MAX : D;
      pre_d = '0;
    end else begin
      if (En) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (!at_end) begin
          q_d = Up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
        end else if (!Sat) begin
          q_d    = Up ? '0 : MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      q_q    <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
    end
  end

  // Tc fires on the end-of-range tick regardless of Sat so cascaded stages still chain.
  assign Tc   = ~Clr & ~Load & tick & at_end;
  assign Q    = q_q;
  assign Wrap = wrap_q;

`ifdef COUNTER_UPDOWN_HEX_DISPLAY_EN
  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    seg7_decoder u_dec (
      .nib (q_q[4*k +: 4]),
      .seg (HEX[SEG_W*k +: SEG_W])
    );
  end
`else
  assign HEX = '1;
`endif

endmodule

// File: tb/tb_counter_updown_hex.sv
// Directed bench: three counter instances (natural wrap, modulus 10, prescale 4) sharing one stimulus bus.
module tb_counter_updown_hex;

  logic        Clk = 1'b0;
  logic        Clr, En, Up, Sat, Load;
  logic [15:0] D;

  logic [15:0] q0, q1, q2;
  logic        tc0, tc1, tc2;
  logic        w0, w1, w2;
  logic [27:0] hex0, hex1, hex2;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  counter_updown_hex #(.WIDTH(16), .MODULUS(0), .PRESCALE(1)) u0 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Sat(Sat), .Load(Load), .D(D),
    .Q(q0), .Tc(tc0), .Wrap(w0), .HEX(hex0));

  counter_updown_hex #(.WIDTH(16), .MODULUS(10), .PRESCALE(1)) u1 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Sat(Sat), .Load(Load), .D(D),
    .Q(q1), .Tc(tc1), .Wrap(w1), .HEX(hex1));

  counter_updown_hex #(.WIDTH(16), .MODULUS(0), .PRESCALE(4)) u2 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Sat(Sat), .Load(Load), .D(D),
    .Q(q2), .Tc(tc2), .Wrap(w2), .HEX(hex2));

`ifdef COUNTER_UPDOWN_HEX_DISPLAY_EN
  localparam logic [27:0] HEX_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] HEX_00AA = {7'h40, 7'h40, 7'h08, 7'h08};
  localparam logic [6:0]  DIG_A    = 7'h08;
`else
  localparam logic [27:0] HEX_0000 = 28'hFFFFFFF;
  localparam logic [27:0] HEX_00AA = 28'hFFFFFFF;
  localparam logic [6:0]  DIG_A    = 7'h7F;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    Clr = 1'b0; En = 1'b0; Up = 1'b1; Sat = 1'b0; Load = 1'b0; D = '0;
    #1;

    // Reset
    Load = 1'b1; D = 16'h1234;
    cyc(1);
    chk("load_1234", 32'(q0), 32'h1234);
    Load = 1'b0; Clr = 1'b1; En = 1'b1;
    #1;
    chk("tc_during_clr", 32'(tc0), 32'h0);
    cyc(1);
    chk("clr_q", 32'(q0), 32'h0);
    chk("clr_wrap", 32'(w0), 32'h0);
    chk("clr_hex", 32'(hex0), 32'(HEX_0000));
    chk("clr_q_mod10", 32'(q1), 32'h0);
    Clr = 1'b0; En = 1'b0;
    #1;
    chk("tc_idle", 32'(tc0), 32'h0);

    // Wrap up, natural modulus
    Load = 1'b1; D = 16'hFFFE;
    cyc(1);
    chk("load_fffe", 32'(q0), 32'hFFFE);
    chk("load_clamp_mod10", 32'(q1), 32'h9);
    Load = 1'b0; En = 1'b1; Up = 1'b1; Sat = 1'b0;
    #1;
    chk("tc_fffe", 32'(tc0), 32'h0);
    cyc(1);
    chk("q_ffff", 32'(q0), 32'hFFFF);
    chk("wrap_before", 32'(w0), 32'h0);
    chk("mod10_wrap_q", 32'(q1), 32'h0);
    chk("mod10_wrap_pulse", 32'(w1), 32'h1);
    chk("tc_ffff", 32'(tc0), 32'h1);
    cyc(1);
    chk("q_wrapped", 32'(q0), 32'h0);
    chk("wrap_pulse", 32'(w0), 32'h1);
    En = 1'b0;
    cyc(1);
    chk("wrap_drop", 32'(w0), 32'h0);

    // Modulus 10, counting down
    Load = 1'b1; D = 16'h0001;
    cyc(1);
    chk("m10_load1", 32'(q1), 32'h1);
    Load = 1'b0; Up = 1'b0; En = 1'b1;
    #1;
    chk("m10_tc_at1", 32'(tc1), 32'h0);
    cyc(1);
    chk("m10_q0", 32'(q1), 32'h0);
    chk("m10_nowrap", 32'(w1), 32'h0);
    chk("m10_tc_at0", 32'(tc1), 32'h1);
    cyc(1);
    chk("m10_q9", 32'(q1), 32'h9);
    chk("m10_wrap", 32'(w1), 32'h1);
    En = 1'b0; Load = 1'b1; D = 16'h000F;
    cyc(1);
    chk("m10_clamp15", 32'(q1), 32'h9);
    chk("m10_wrap_clr_by_load", 32'(w1), 32'h0);

    // Saturate at MAX
    D = 16'hFFFF;
    cyc(1);
    Load = 1'b0; Sat = 1'b1; Up = 1'b1; En = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sat_tc", 32'(tc0), 32'h1);
      cyc(1);
      chk("sat_q", 32'(q0), 32'hFFFF);
      chk("sat_wrap", 32'(w0), 32'h0);
    end
    chk("sat_mod10_q", 32'(q1), 32'h9);
    chk("sat_mod10_wrap", 32'(w1), 32'h0);
    // Load at the end of range suppresses Tc even with a pending tick
    Load = 1'b1;
    #1;
    chk("tc_masked_by_load", 32'(tc0), 32'h0);
    En = 1'b0; Sat = 1'b0;

    // Prescale 4
    D = 16'h0000;
    cyc(1);
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    cyc(3);
    chk("pre_no_step_yet", 32'(q2), 32'h0);
    cyc(1);
    chk("pre_first_step", 32'(q2), 32'h1);
    cyc(8);
    chk("pre_12_cycles", 32'(q2), 32'h3);
    En = 1'b0; Load = 1'b1;
    cyc(1);
    Load = 1'b0; En = 1'b1;
    cyc(5);
    chk("pre_mid_5en", 32'(q2), 32'h1);
    En = 1'b0;
    cyc(2);
    chk("pre_hold", 32'(q2), 32'h1);
    En = 1'b1;
    cyc(2);
    chk("pre_delayed", 32'(q2), 32'h1);
    cyc(1);
    chk("pre_step_after_gap", 32'(q2), 32'h2);
    cyc(4);
    chk("pre_gap_total", 32'(q2), 32'h3);
    En = 1'b0;

    // Priority and load-with-En-low
    Clr = 1'b1; Load = 1'b1; D = 16'h00AA;
    cyc(1);
    chk("clr_beats_load", 32'(q0), 32'h0);
    chk("clr_beats_load_m10", 32'(q1), 32'h0);
    Clr = 1'b0;
    cyc(1);
    chk("load_en_low", 32'(q0), 32'h00AA);
    chk("load_en_low_m10", 32'(q1), 32'h9);
    chk("hex_digit0", 32'(hex0[6:0]), 32'(DIG_A));
    chk("hex_00aa", 32'(hex0), 32'(HEX_00AA));
    Load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
